button_debounce: RTL and testbench

- Conditions a raw push-button or switch input before it reaches the long-press detector: 2-flop synchroniser, optional polarity inversion, time-qualified debounce FSM.
- Produces a clean level `out` that feeds the long-press block's `in`.
- Also produces single-cycle press/release strobes and a busy flag.
- Timing is set in nanoseconds, matching the long-press block's parameter style.

---
 rtl/button_debounce.sv | 129 ++++++++++++
 tb/tb_button_debounce.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce : synchroniser + polarity fix + time-qualified debounce FSM
// Rev 1.0
// ============================================================================
module button_debounce #(
    parameter int CLK_PERIOD_ns = 20,
    parameter int DEBOUNCE_ns   = 100,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int COUNT = ((DEBOUNCE_ns / CLK_PERIOD_ns) < 1) ? 1 : (DEBOUNCE_ns / CLK_PERIOD_ns);
    localparam int CW    = ($clog2(COUNT + 1) < 1) ? 1 : $clog2(COUNT + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    logic          w_x;
    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;

    // Inversion ahead of the synchroniser so reset level means "not pressed".
    assign w_x = in ^ (ACTIVE_LOW != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_x;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            out     <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (r_state)
                STABLE_LOW: begin
                    if (r_sync2) begin
                        if (COUNT == 1) begin
                            r_state <= STABLE_HIGH;
                            out     <= 1'b1;
                            rise    <= 1'b1;
                        end else begin
                            r_state <= WAIT_HIGH;
                            r_cnt   <= CW'(1);
                            busy    <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!r_sync2) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        out     <= 1'b1;
                        rise    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!r_sync2) begin
                        if (COUNT == 1) begin
                            r_state <= STABLE_LOW;
                            out     <= 1'b0;
                            fall    <= 1'b1;
                        end else begin
                            r_state <= WAIT_LOW;
                            r_cnt   <= CW'(1);
                            busy    <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (r_sync2) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        out     <= 1'b0;
                        fall    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                    out     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// tb_button_debounce : scoreboard bench, three configurations driven in lockstep
// Rev 1.0
// ============================================================================
module tb_button_debounce;

    typedef struct packed {
        logic out;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lvl = 1'b0;
    logic [2:0] din;
    logic [2:0] dout;
    logic [2:0] drise;
    logic [2:0] dfall;
    logic [2:0] dbusy;

    int n_vec  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    // Instance 0: COUNT=5; instance 1: COUNT=5 active-low pin; instance 2: COUNT=1.
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DEB = (g == 2) ? 10 : 100;
        localparam int AL  = (g == 1) ? 1 : 0;
        localparam int CNT = ((DEB / 20) < 1) ? 1 : (DEB / 20);

        exp_t q[$];
        bit   p1, p2, mout;
        bit   hist[$];

        assign din[g] = (AL == 1) ? ~lvl : lvl;

        button_debounce #(
            .CLK_PERIOD_ns(20),
            .DEBOUNCE_ns  (DEB),
            .ACTIVE_LOW   (AL)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .in  (din[g]),
            .out (dout[g]),
            .rise(drise[g]),
            .fall(dfall[g]),
            .busy(dbusy[g])
        );

        // Mid-cycle reset: the pending expectation becomes all-zero immediately.
        always @(posedge rst) begin
            p1 = 0; p2 = 0; mout = 0;
            hist.delete();
            if (q.size() > 0) begin
                q.delete();
                q.push_back('0);
            end
        end

        // Reference: out flips once the last CNT levels seen past the synchroniser all differ from it.
        always @(posedge clk) begin
            exp_t e;
            bit   s, all;
            if (rst) begin
                p1 = 0; p2 = 0; mout = 0;
                hist.delete();
                q.push_back('0);
            end else begin
                s  = p2;
                p2 = p1;
                p1 = lvl;
                hist.push_back(s);
                if (hist.size() > CNT) void'(hist.pop_front());
                all = (hist.size() == CNT);
                foreach (hist[i]) if (hist[i] == mout) all = 0;
                e = '0;
                if (all) begin
                    mout   = !mout;
                    e.rise = mout;
                    e.fall = !mout;
                end
                e.out  = mout;
                e.busy = (s != mout);
                q.push_back(e);
            end
        end

        always @(negedge clk) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL inst%0d scoreboard empty at %0t", g, $time);
            end else begin
                e = q.pop_front();
                if ({dout[g], drise[g], dfall[g], dbusy[g]} !== e) begin
                    n_fail++;
                    $display("FAIL inst%0d outputs at %0t: got out/rise/fall/busy=%b%b%b%b want %b",
                             g, $time, dout[g], drise[g], dfall[g], dbusy[g], e);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic v, input int n);
        lvl = v;
        cycles(n);
    endtask

    // Counts edges from the next sampling edge until instance 0 shows level v.
    task automatic wait_out(input logic v, input int exp_edges, input string nm);
        int k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (dout[0] == v) break;
        end
        n_vec++;
        if (k != exp_edges) begin
            n_fail++;
            $display("FAIL %s: out reached %b after %0d edges, want %0d", nm, v, k, exp_edges);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with the button already pressed.
        lvl = 1'b1;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        wait_out(1'b1, 7, "reset_release_rise");

        // Clean press/release.
        drive(1'b1, 20);
        lvl = 1'b0;
        wait_out(1'b0, 7, "release_fall");
        cycles(10);

        // Bounce rejection, then bounce-and-settle.
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 15);
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
        drive(1'b1, 1); drive(1'b0, 1);
        lvl = 1'b1;
        wait_out(1'b1, 7, "bounce_settle_rise");
        cycles(10);
        drive(1'b0, 15);

        // Reset in the middle of qualification.
        drive(1'b1, 3);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dout, drise, dfall, dbusy} !== 12'b0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got out/rise/fall/busy=%b/%b/%b/%b want all 0",
                     dout, drise, dfall, dbusy);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_out(1'b1, 7, "post_reset_rise");
        cycles(5);

        // Randomised runs with occasional resets.
        for (int it = 0; it < 90; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 2));
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end

        drive(1'b0, 20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
